// File: rtl/wb_stage_if.sv
// wb_stage_if: result handshake from the long-latency unit (divider) into the
// writeback stage. The master is the long-latency unit; the slave is wb_stage.
interface wb_stage_if;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;

  modport master (output lu_valid, output lu_rd, output lu_data, input lu_ready);
  modport slave  (input lu_valid, input lu_rd, input lu_data, output lu_ready);
endinterface

// File: rtl/wb_stage.sv
// wb_stage: RV32 writeback stage -- MEM/WB register, result mux, register file write
// port, and a one-entry buffer merging long-latency results. Macro WB_LOAD_EXT_EN
// enables load byte/halfword extraction and extension in this stage.
module wb_stage (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mw_valid,
  input  logic             mw_regwrite,
  input  logic [4:0]       mw_rd,
  input  logic [1:0]       mw_resultsrc,
  input  logic [31:0]      mw_alu,
  input  logic [31:0]      mw_rdata,
  input  logic [31:0]      mw_pc4,
  input  logic [2:0]       mw_funct3,
  wb_stage_if.slave        lu,
  output logic             we,
  output logic [4:0]       rd,
  output logic [31:0]      wd,
  output logic             lu_pend,
  output logic [4:0]       lu_pend_rd
);

  logic        valid_q, valid_d;
  logic        regWrite_q, regWrite_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  resultSrc_q, resultSrc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] pc4_q, pc4_d;

  logic        bufFull_q, bufFull_d;
  logic [4:0]  bufRd_q, bufRd_d;
  logic [31:0] bufData_q, bufData_d;

  logic        pipeWr;
  logic        luAccept;
  logic [31:0] loadData;
  logic [31:0] result;

  always_comb begin
    valid_d     = valid_q;
    regWrite_d  = regWrite_q;
    rd_d        = rd_q;
    resultSrc_d = resultSrc_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    pc4_d       = pc4_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      regWrite_d = 1'b0;
    end else if (!stall_i) begin
      valid_d     = mw_valid;
      regWrite_d  = mw_regwrite;
      rd_d        = mw_rd;
      resultSrc_d = mw_resultsrc;
      alu_d       = mw_alu;
      rdata_d     = mw_rdata;
      pc4_d       = mw_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      regWrite_q  <= 1'b0;
      rd_q        <= 5'd0;
      resultSrc_q <= 2'd0;
      alu_q       <= 32'd0;
      rdata_q     <= 32'd0;
      pc4_q       <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      regWrite_q  <= regWrite_d;
      rd_q        <= rd_d;
      resultSrc_q <= resultSrc_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      pc4_q       <= pc4_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0]  funct3_q;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= 3'd0;
    end else if (!flush_i && !stall_i) begin
      funct3_q <= mw_funct3;
    end
  end

  // Misaligned offsets are deliberately not checked; the byte lane is taken as-is.
  always_comb begin
    case (alu_q[1:0])
      2'd1:    loadByte = rdata_q[15:8];
      2'd2:    loadByte = rdata_q[23:16];
      2'd3:    loadByte = rdata_q[31:24];
      default: loadByte = rdata_q[7:0];
    endcase
    loadHalf = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {24'd0, loadByte};
      3'b101:  loadData = {16'd0, loadHalf};
      default: loadData = rdata_q;
    endcase
  end
`else
  logic unusedFunct3;
  assign unusedFunct3 = ^mw_funct3;
  assign loadData     = rdata_q;
`endif

  always_comb begin
    case (resultSrc_q)
      2'b01:   result = loadData;
      2'b10:   result = pc4_q;
      default: result = alu_q;
    endcase
  end

  assign pipeWr = valid_q & regWrite_q & (rd_q != 5'd0);

  // The pipeline always owns the port; the buffer only drains in a free cycle.
  always_comb begin
    we = 1'b0;
    rd = 5'd0;
    wd = 32'd0;
    if (pipeWr) begin
      we = 1'b1;
      rd = rd_q;
      wd = result;
    end else if (bufFull_q) begin
      we = 1'b1;
      rd = bufRd_q;
      wd = bufData_q;
    end
  end

  // No accept-and-drain bypass: ready stays low for the whole cycle the buffer is full.
  assign lu.lu_ready = ~bufFull_q;
  assign luAccept    = lu.lu_valid & ~bufFull_q;

  always_comb begin
    bufFull_d = bufFull_q;
    bufRd_d   = bufRd_q;
    bufData_d = bufData_q;
    if (bufFull_q && !pipeWr) begin
      bufFull_d = 1'b0;
    end
    if (luAccept && (lu.lu_rd != 5'd0)) begin
      bufFull_d = 1'b1;
      bufRd_d   = lu.lu_rd;
      bufData_d = lu.lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufFull_q <= 1'b0;
      bufRd_q   <= 5'd0;
      bufData_q <= 32'd0;
    end else begin
      bufFull_q <= bufFull_d;
      bufRd_q   <= bufRd_d;
      bufData_q <= bufData_d;
    end
  end

  assign lu_pend    = bufFull_q;
  assign lu_pend_rd = bufFull_q ? bufRd_q : 5'd0;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32 pipeline. Holds the MEM/WB pipeline register, selects the writeback value, and drives the register file write port (`we`/`rd`/`wd`). It also merges results from one long-latency unit (M-extension divider) through a one-entry buffer, so that only one write reaches the register file per cycle. Hazard status for the pending long-latency result is exported to the hazard unit.

## Interface
- Parameters: none.
- Ports:
  - `clk  in  1`: clock; all state updates on rising edge (register file writes on falling edge of the same cycle).
  - `rst_n  in  1`: asynchronous active-low reset.
  - `stall_i  in  1`: hold the WB stage register.
  - `flush_i  in  1`: load a bubble into the WB stage register; takes priority over `stall_i`.
  - `mw_valid  in  1`: MEM/WB slot holds a real instruction.
  - `mw_regwrite  in  1`: instruction writes `rd`.
  - `mw_rd  in  5`: destination register.
  - `mw_resultsrc  in  2`: result select. 00 = ALU, 01 = load data, 10 = PC+4, 11 = ALU.
  - `mw_alu  in  32`: ALU result / effective address.
  - `mw_rdata  in  32`: raw load word from data memory.
  - `mw_pc4  in  32`: PC+4.
  - `mw_funct3  in  3`: load width and sign.
  - `lu_valid  in  1`: long-latency result offered.
  - `lu_ready  out  1`: buffer can accept; equals `!buf_full`.
  - `lu_rd  in  5`: long-latency destination register.
  - `lu_data  in  32`: long-latency result.
  - `we  out  1`: register file write enable.
  - `rd  out  5`: register file write address.
  - `wd  out  32`: register file write data.
  - `lu_pend  out  1`: buffer holds an undrained result.
  - `lu_pend_rd  out  5`: destination of the buffered result; 0 when `!lu_pend`.

## Operation
- **WB register.** On the rising edge:
  - `flush_i`: valid and regwrite cleared.
  - else `!stall_i`: captures all `mw_*` inputs.
  - else: holds.
- **Result mux.** Based on the registered `resultsrc`: ALU, extended load data, or PC+4.
- **Pipeline write.** `pipe_wr = valid & regwrite & (rd != 0)`.
- **Port arbitration.** Combinational.
  - `pipe_wr`: `we=1`, `rd`/`wd` come from the pipeline. The pipeline always wins.
  - else `buf_full`: `we=1`, `rd`/`wd` come from the buffer, and the buffer drains (`buf_full` clears at the next rising edge).
  - else: `we=0`, `rd=0`, `wd=0`.
- **Buffer accept.** On a rising edge with `lu_valid & lu_ready`:
  - `lu_rd != 0`: buffer loads, `buf_full=1`.
  - `lu_rd == 0`: handshake completes and the data is discarded; buffer stays empty.
- **No accept-and-drain bypass.** `lu_ready` is low the whole cycle the buffer is full, even if it drains that cycle.
- **Stall.** A held WB instruction rewrites the same value each cycle, which is idempotent. During a stall the buffer drains only if the held slot has `pipe_wr=0`.
- **WAW ordering.** Not resolved here. The hazard unit must stall issue of any instruction whose `rd` equals `lu_pend_rd` while `lu_pend`, and any in-flight divide target.

## Timing
- **Reset values.** WB valid=0, `buf_full=0`, so `we=0`, `rd=0`, `wd=0`, `lu_pend=0`, `lu_pend_rd=0`. `lu_ready=1` immediately after reset.
- **Pipeline latency.** An instruction captured at edge N drives `we`/`rd`/`wd` during cycle N to N+1. The register file writes at the falling edge of that cycle and read-bypasses during the same cycle.
- **Long-latency path.**
  - Accepted at edge N: earliest write is in cycle N to N+1.
  - Each cycle with `pipe_wr=1` delays it by one cycle.
  - Buffer occupancy: at least 1 cycle, unbounded under back-to-back pipeline writes.
- **Reset mid-operation.** The buffer content is lost; the upstream unit must also be reset.
- **Simultaneous events.**
  - `flush_i` together with a buffered result: the buffer drains in the first cycle with no pipeline write.
  - `lu_valid` while full: no accept; upstream holds its data stable until `lu_ready`.

## Configuration
- Macro: `WB_LOAD_EXT_EN`.
- **Defined.** Load data is extracted and extended in this stage, using the byte offset `mw_alu[1:0]` (halfword offset `mw_alu[1]`):
  - `funct3` 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: word unchanged.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - Other codes: word unchanged.
  - Misaligned addresses are not checked.
- **Undefined.** `mw_rdata` is written unchanged; `mw_funct3` is ignored and the memory stage performs extension.

## Test plan
- **Reset.** Assert `rst_n=0` mid-cycle, with the buffer full from an accepted `lu_rd=7` → `we=0`, `lu_pend=0`, `lu_ready=1` with no clock edge.
- **Pipeline writes.** ALU write `rd=5`, `alu=0x1234` → `we=1`, `rd=5`, `wd=0x1234` one cycle after capture. The same instruction with `rd=0` → `we=0`.
- **Arbitration.** Accept `lu_rd=9`, `lu_data=0xDEAD`, then send 3 back-to-back pipeline writes → buffer write appears in cycle 4 with `lu_pend_rd=9` throughout, and `lu_ready=0` until the drain edge.
- **Stall and flush.** Hold `stall_i` for 3 cycles with a load in WB → same `rd`/`wd` for 3 cycles. `flush_i` with `stall_i` → `we=0` next cycle.
- **Extension (`WB_LOAD_EXT_EN`).** `rdata=0x80FF7F01`:
  - LB at offset 3 → `0xFFFFFF80`.
  - LBU at offset 2 → `0x000000FF`.
  - LH at offset 0 → `0x00007F01`.
  - Without the macro, every load → `0x80FF7F01`.
- **Zero destination.** `lu_valid` with `lu_rd=0` → handshake completes, `lu_pend` stays 0, no write.
